load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- MEM-stage access controller between the pipeline's EX/MEM register and the word-wide data memory (MemRead/MemWrite, 9-bit byte address, 32-bit data, combinational read).
- Converts RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Sub-word stores use a read-modify-write sequence because the memory has no byte enables.
- Loads are aligned and sign/zero-extended; misaligned and illegal requests are flagged.

Parameters:
ADDR_W, 9, byte-address width to data memory (word index = addr[ADDR_W-1:2])

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  pipeline request present
req_ready  out  1  unit can accept request this cycle
req_write  in  1  1=store, 0=load
funct3  in  3  RV32I width/sign code
addr  in  ADDR_W  byte address
wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
rdata  out  32  extended load result (valid with resp_valid, loads only)
err  out  1  with resp_valid: misaligned or illegal funct3
MemRead  out  1  to data memory
MemWrite  out  1  to data memory
mem_addr  out  ADDR_W  to data memory, low 2 bits always 0
mem_wdata  out  32  to data memory
mem_rdata  in  32  from data memory (combinational)

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. Registered request fields, rdata, mem_addr, mem_wdata all 0; resp_valid=0, err=0. MemRead and MemWrite are gated by rst_n, so they are 0 in any cycle rst_n=0. Any in-flight RMW is abandoned; no write occurs.
- States: IDLE, RD, RMW_RD, WR, RESP.
- req_ready=1 only in IDLE. A handshake is req_valid&req_ready; the request is registered on that edge.
- funct3 legality:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU are legal.
  - Stores: 000 SB, 001 SH, 010 SW are legal.
  - Anything else is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Transitions from IDLE on handshake:
  - Illegal or misaligned -> RESP with err=1. No memory access.
  - Load -> RD.
  - SW -> WR.
  - SB/SH -> RMW_RD.
- RD: MemRead=1. Capture the extended mem_rdata into rdata. -> RESP.
- RMW_RD: MemRead=1. Capture mem_rdata. -> WR.
- WR: MemWrite=1 for exactly one cycle.
  - SW: mem_wdata=wdata.
  - SB: merges wdata[7:0] into byte lane addr[1:0].
  - SH: merges wdata[15:0] into lane addr[1].
  - Other bytes keep the captured word.
  - -> RESP.
- RESP: resp_valid=1 for one cycle; err as decided. -> IDLE.
- rdata holds its value until the next load completes. Stores leave rdata unchanged.
- Latency from handshake edge to resp_valid: load 2 cycles, SW 2, SB/SH 3, error 1. Throughput: one request per latency+1 cycles.
- Extension:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - Lane = addr[1:0] for bytes, addr[1] for halves.
- mem_addr = {addr[ADDR_W-1:2],2'b00}, held stable from the cycle after the handshake through WR.
- Outside RD/RMW_RD/WR: MemRead=MemWrite=0.
- No response backpressure: the pipeline must stall on req_ready=0.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: misaligned requests take the error path (err=1, no access), as above.
- Undefined: no misalignment check. addr is truncated to natural alignment (addr[0] cleared for halves, addr[1:0] cleared for words) and the access proceeds. err is raised only for illegal funct3.

Test Plan:
- Reset: hold rst_n=0 during a WR cycle of an SB -> MemWrite=0, memory word unchanged, req_ready=1, outputs 0 on release.
- Word store/load: SW addr=0x010 wdata=0xDEADBEEF, then LW addr=0x010 -> MemWrite one cycle at word 4; resp_valid 2 cycles after each handshake; rdata=0xDEADBEEF.
- Byte RMW: memory word 4=0x11223344, SB addr=0x012 wdata=0xAB -> RMW_RD then WR, word=0x11AB3344, resp 3 cycles after handshake.
- Sign/zero extension: word=0x80FF7F01. LB 0x013 -> 0xFFFFFF80; LBU 0x013 -> 0x00000080; LH 0x010 -> 0x00007F01; LHU 0x012 -> 0x000080FF.
- Misalign/illegal, with MISALIGN_TRAP_EN:
  - LW addr=0x011 -> err=1 after 1 cycle, MemRead never 1.
  - funct3=011 -> err=1.
  - Without the macro: LW addr=0x011 reads word 4, err=0.
- Back-to-back: req_valid held high with 3 queued requests -> req_ready low except in IDLE; each request accepted exactly once, in order.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage controller that turns RV32I loads/stores into
// accesses on a word-wide data memory with no byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-aligned and
// sign/zero-extended.
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word requests complete with err=1 and no access
//   undefined -> addresses are truncated to natural alignment and the access proceeds
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE, so the pipeline must hold its request until it
// is accepted. The response is a single-cycle resp_valid pulse; err and rdata are
// meaningful while resp_valid is high. There is no response backpressure.
module load_store_unit #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t              state_q;
    logic [2:0]          funct3_q;
    logic [1:0]          lane_q;
    logic [15:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                resp_valid_q;
    logic                err_q;

    logic                f3_legal;
    logic                is_half;
    logic                is_word;
    logic                req_err;
    logic [ADDR_W-1:0]   addr_eff;
    logic [31:0]         load_ext;
    logic [31:0]         merged;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;

    // Decode legality / alignment of the request presented at the input
    always_comb begin
        f3_legal = 1'b0;
        if (req_write) begin
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        is_half  = (funct3[1:0] == 2'b01);
        is_word  = (funct3[1:0] == 2'b10);
        addr_eff = addr;
`ifdef MISALIGN_TRAP_EN
        req_err  = !f3_legal || (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
        // Without trapping, force natural alignment so the access stays in one word
        req_err  = !f3_legal;
        if (is_half) addr_eff[0] = 1'b0;
        if (is_word) addr_eff[1:0] = 2'b00;
`endif
    end

    // Select the addressed lane of the memory word and extend it for the load result
    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h000000, byte_sel};
            3'b101:  load_ext = {16'h0000, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Merge store data into the word just read for the RMW write-back
    always_comb begin
        merged = mem_rdata;
        if (funct3_q[1:0] == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    // Main FSM with registered request fields and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0000;
            rdata_q      <= 32'h0000_0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        funct3_q <= funct3;
                        lane_q   <= addr_eff[1:0];
                        wdata_q  <= wdata[15:0];
                        err_q    <= req_err;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            mem_addr_q <= {addr_eff[ADDR_W-1:2], 2'b00};
                            if (!req_write) begin
                                state_q <= RD;
                            end else if (funct3 == 3'b010) begin
                                mem_wdata_q <= wdata;
                                state_q     <= WR;
                            end else begin
                                state_q <= RMW_RD;
                            end
                        end
                    end
                end
                RD: begin
                    rdata_q      <= load_ext;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RMW_RD: begin
                    mem_wdata_q <= merged;
                    state_q     <= WR;
                end
                WR: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    // Strobes are gated by rst_n so an abandoned RMW never writes during reset
    assign MemRead     = rst_n && ((state_q == RD) || (state_q == RMW_RD));
    assign MemWrite    = rst_n && (state_q == WR);
    assign dbg_state_o = state_q;

endmodule
